// File: rtl/systolic_feeder.sv
// Front end for an NxN systolic multiply grid: latches operands, clears the array,
// streams diagonally skewed rows/columns into its edges, then holds the captured result.
module systolic_feeder #(
   parameter int MATRIX_SIZE = 3,
   parameter int DATA_WIDTH  = 8,
   parameter int ACC_WIDTH   = 32
) (
   input  logic                                                   clk,
   input  logic                                                   rst,
   input  logic                                                   start_valid,
   output logic                                                   start_ready,
   input  logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] a_mat,
   input  logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] b_mat,
   output logic                                                   arr_clr,
   output logic                                                   arr_en,
   output logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0]                 arr_left,
   output logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0]                 arr_top,
   input  logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][ACC_WIDTH-1:0]  arr_acc,
   output logic                                                   res_valid,
   input  logic                                                   res_ready,
   output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][ACC_WIDTH-1:0]  res_data,
   output logic                                                   busy
);

   localparam int N        = MATRIX_SIZE;
   localparam int FEED_LEN = 3 * N - 2;
   localparam int TW       = $clog2(FEED_LEN + 1);
   localparam logic [TW-1:0] T_LAST = TW'(FEED_LEN - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      FEED    = 3'd2,
      CAPTURE = 3'd3,
      HOLD    = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   t_q, t_d;
   logic [N-1:0][N-1:0][DATA_WIDTH-1:0] a_q, b_q;
   logic [N-1:0][N-1:0][ACC_WIDTH-1:0]  res_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         t_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         if (state_q == IDLE && start_valid) begin
            a_q <= a_mat;
            b_q <= b_mat;
         end
         if (state_q == CAPTURE) begin
            res_q <= arr_acc;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      case (state_q)
         IDLE:    if (start_valid) state_d = CLEAR;
         CLEAR: begin
            state_d = FEED;
            t_d     = '0;
         end
         FEED: begin
            if (t_q == T_LAST) begin
               state_d = CAPTURE;
               t_d     = '0;
            end else begin
               t_d = t_q + 1'b1;
            end
         end
         CAPTURE: state_d = HOLD;
         HOLD:    if (res_ready) state_d = IDLE;
         default: begin
            state_d = IDLE;
            t_d     = '0;
         end
      endcase
   end

   assign start_ready = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign arr_clr     = (state_q == CLEAR);
   assign arr_en      = (state_q == FEED);
   assign res_valid   = (state_q == HOLD);
   assign res_data    = res_q;

   // Edge lane gi carries element k of its row/column when t == gi + k; zero elsewhere.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_edge
         logic [DATA_WIDTH-1:0] left_v, top_v;
         always_comb begin
            left_v = '0;
            top_v  = '0;
            if (state_q == FEED) begin
               for (int k = 0; k < N; k++) begin
                  if (t_q == TW'(gi + k)) begin
                     left_v = a_q[gi][k];
                     top_v  = b_q[k][gi];
                  end
               end
            end
         end
         assign arr_left[gi] = left_v;
         assign arr_top[gi]  = top_v;
      end
   endgenerate

endmodule
